// File: rtl/tx_symbol_demap_pack.sv
// M-PAM detected-symbol mapper and bit packer with a show-ahead output FIFO.
// Optional macro GRAY_MAP_EN selects Gray-coded field bits instead of natural binary.
module tx_symbol_demap_pack #(
    parameter int N          = 32,
    parameter int Q          = 22,
    parameter int LOG2M      = 2,
    parameter int NSYM       = 2,
    parameter int QBITS      = 5,
    parameter int FIFO_DEPTH = 4,
    localparam int IW        = LOG2M + 1,
    localparam int W         = QBITS + 2 * NSYM * LOG2M,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NSYM*IW-1:0]  m_I,
    input  logic [NSYM*IW-1:0]  m_Q,
    input  logic [QBITS-1:0]    q_min,
    output logic [NSYM*N-1:0]   s_hat_I,
    output logic [NSYM*N-1:0]   s_hat_Q,
    output logic [QBITS-1:0]    s_hat_index,
    output logic                sym_valid,
    output logic [W-1:0]        word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [CW-1:0]       fifo_count,
    output logic                err_idx
);

    localparam int M  = 2 ** LOG2M;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [IW-1:0] KMAX = IW'(M);

    function automatic logic k_bad(input logic [IW-1:0] k);
        return (k == '0) || (k > KMAX);
    endfunction

    // Level (2k-M-1) * 2**Q, sign-extended to N bits; illegal indices map to 0.
    function automatic logic [N-1:0] level(input logic [IW-1:0] k);
        int t;
        if (k_bad(k)) return '0;
        t = 2 * int'(k) - M - 1;
        return N'(t) << Q;
    endfunction

    function automatic logic [LOG2M-1:0] field(input logic [IW-1:0] k);
        logic [LOG2M-1:0] g;
        if (k_bad(k)) return '0;
        g = LOG2M'(k - 1'b1);
`ifdef GRAY_MAP_EN
        return g ^ (g >> 1);
`else
        return g;
`endif
    endfunction

    logic [NSYM*N-1:0] w_lvl_I, w_lvl_Q;
    logic [W-1:0]      w_word;
    logic              w_bad, w_push, w_pop;

    logic [NSYM*N-1:0] r_s_hat_I, r_s_hat_Q;
    logic [QBITS-1:0]  r_s_hat_index;
    logic              r_sym_valid, r_err_idx;
    logic [W-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    always_comb begin
        w_lvl_I = '0;
        w_lvl_Q = '0;
        w_word  = '0;
        w_bad   = 1'b0;
        w_word[W-1 -: QBITS] = q_min;
        for (int unsigned s = 0; s < NSYM; s++) begin
            w_lvl_I[s*N +: N] = level(m_I[s*IW +: IW]);
            w_lvl_Q[s*N +: N] = level(m_Q[s*IW +: IW]);
            w_word[W-QBITS-(2*s+1)*LOG2M +: LOG2M] = field(m_I[s*IW +: IW]);
            w_word[W-QBITS-(2*s+2)*LOG2M +: LOG2M] = field(m_Q[s*IW +: IW]);
            w_bad = w_bad | k_bad(m_I[s*IW +: IW]) | k_bad(m_Q[s*IW +: IW]);
        end
    end

    // Handshakes depend only on registered occupancy, never on word_ready combinationally into in_ready.
    assign in_ready = (r_count != CW'(FIFO_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && word_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_hat_I     <= '0;
            r_s_hat_Q     <= '0;
            r_s_hat_index <= '0;
            r_sym_valid   <= 1'b0;
            r_err_idx     <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_sym_valid <= w_push;
            if (w_push) begin
                r_s_hat_I      <= w_lvl_I;
                r_s_hat_Q      <= w_lvl_Q;
                r_s_hat_index  <= q_min;
                r_mem[r_wptr]  <= w_word;
                r_wptr         <= r_wptr + 1'b1;
                if (w_bad) r_err_idx <= 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign s_hat_I     = r_s_hat_I;
    assign s_hat_Q     = r_s_hat_Q;
    assign s_hat_index = r_s_hat_index;
    assign sym_valid   = r_sym_valid;
    assign word_out    = r_mem[r_rptr];
    assign word_valid  = (r_count != '0);
    assign fifo_count  = r_count;
    assign err_idx     = r_err_idx;

endmodule

// File: tb/tb_tx_symbol_demap_pack.sv
// Self-checking bench: directed cases plus randomized traffic against a queue-based model.
module tb_tx_symbol_demap_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  m_I = '0, m_Q = '0;
    logic [4:0]  q_min = '0;
    logic [63:0] s_hat_I, s_hat_Q;
    logic [4:0]  s_hat_index;
    logic        sym_valid;
    logic [12:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        err_idx;

    // Second instance: 8-PAM, one symbol, for the wider-index levels.
    logic        i8_valid = 1'b0, i8_ready;
    logic [3:0]  i8_I = '0, i8_Q = '0;
    logic [4:0]  i8_q = '0;
    logic [31:0] o8_I, o8_Q;
    logic [4:0]  o8_idx;
    logic        o8_sv, o8_wv, o8_err;
    logic [10:0] o8_word;
    logic [1:0]  o8_cnt;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    tx_symbol_demap_pack #(.N(32), .Q(22), .LOG2M(2), .NSYM(2), .QBITS(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m_I(m_I), .m_Q(m_Q), .q_min(q_min),
        .s_hat_I(s_hat_I), .s_hat_Q(s_hat_Q), .s_hat_index(s_hat_index), .sym_valid(sym_valid),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_count(fifo_count), .err_idx(err_idx)
    );

    tx_symbol_demap_pack #(.N(32), .Q(22), .LOG2M(3), .NSYM(1), .QBITS(5), .FIFO_DEPTH(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(i8_ready),
        .m_I(i8_I), .m_Q(i8_Q), .q_min(i8_q),
        .s_hat_I(o8_I), .s_hat_Q(o8_Q), .s_hat_index(o8_idx), .sym_valid(o8_sv),
        .word_out(o8_word), .word_valid(o8_wv), .word_ready(1'b0),
        .fifo_count(o8_cnt), .err_idx(o8_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic straight from the mapping rules.
    function automatic logic [31:0] lvl(input int k, input int m);
        longint v;
        if (k < 1 || k > m) return 32'd0;
        v = longint'(2 * k - m - 1) * (longint'(1) << 22);
        return 32'(v);
    endfunction

    function automatic int fld(input int k, input int m);
        int g;
        if (k < 1 || k > m) return 0;
        g = k - 1;
`ifdef GRAY_MAP_EN
        return g ^ (g >> 1);
`else
        return g;
`endif
    endfunction

    int          ki[2], kq[2], qv;
    logic [12:0] mq[$];
    logic [31:0] eI[2], eQ[2];
    int          eidx;
    bit          eerr, esv;

    function automatic logic [12:0] exp_word();
        int w = qv;
        for (int s = 0; s < 2; s++) begin
            w = w * 4 + fld(ki[s], 4);
            w = w * 4 + fld(kq[s], 4);
        end
        return 13'(w);
    endfunction

    task automatic set_block(input int i0, input int q0, input int i1, input int q1, input int qm);
        ki[0] = i0; kq[0] = q0; ki[1] = i1; kq[1] = q1; qv = qm;
        m_I   = {3'(i1), 3'(i0)};
        m_Q   = {3'(q1), 3'(q0)};
        q_min = 5'(qm);
    endtask

    task automatic model_clear();
        mq.delete();
        eI[0] = 0; eI[1] = 0; eQ[0] = 0; eQ[1] = 0;
        eidx = 0; eerr = 0; esv = 0;
    endtask

    task automatic compare_all();
        check("sym_valid", 64'(sym_valid), 64'(esv));
        check("in_ready", 64'(in_ready), 64'(mq.size() != 4));
        check("word_valid", 64'(word_valid), 64'(mq.size() != 0));
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check("err_idx", 64'(err_idx), 64'(eerr));
        check("s_hat_I0", 64'(s_hat_I[31:0]), 64'(eI[0]));
        check("s_hat_I1", 64'(s_hat_I[63:32]), 64'(eI[1]));
        check("s_hat_Q0", 64'(s_hat_Q[31:0]), 64'(eQ[0]));
        check("s_hat_Q1", 64'(s_hat_Q[63:32]), 64'(eQ[1]));
        check("s_hat_index", 64'(s_hat_index), 64'(eidx));
        if (mq.size() != 0) check("word_out", 64'(word_out), 64'(mq[0]));
    endtask

    // One clock with model update; inputs must already be driven.
    task automatic step();
        bit acc, pop;
        logic [12:0] w;
        acc = in_valid && (mq.size() < 4);
        pop = word_ready && (mq.size() > 0);
        w   = exp_word();
        @(posedge clk); #1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(w);
            for (int s = 0; s < 2; s++) begin
                eI[s] = lvl(ki[s], 4);
                eQ[s] = lvl(kq[s], 4);
                if (ki[s] < 1 || ki[s] > 4 || kq[s] < 1 || kq[s] > 4) eerr = 1;
            end
            eidx = qv;
        end
        esv = acc;
        compare_all();
    endtask

    function automatic int rk();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(1, 4));
    endfunction

    initial begin
        model_clear();
        set_block(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_hat_I", s_hat_I, 64'd0);
        check("rst_word_out", 64'(word_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        compare_all();
        rst = 1'b0;

        // 8-PAM levels and field width
        i8_valid = 1'b1; i8_I = 4'd1; i8_Q = 4'd8; i8_q = 5'd0;
        step();
        i8_valid = 1'b0;
        check("t4_lvl_k1", 64'(o8_I), 64'hFE400000);
        check("t4_lvl_k8", 64'(o8_Q), 64'h01C00000);
        check("t4_lvl_k1_model", 64'(o8_I), 64'(lvl(1, 8)));
        check("t4_word", 64'(o8_word), 64'(fld(8, 8)));
`ifdef GRAY_MAP_EN
        check("t4_field_k8", 64'(o8_word[2:0]), 64'(3'b100));
`else
        check("t4_field_k8", 64'(o8_word[2:0]), 64'(3'b111));
`endif
        check("t4_misc", {o8_sv, o8_wv, o8_err, i8_ready, o8_cnt, o8_idx}, {1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 5'd0});

        // T1 reference block
        in_valid = 1'b1; set_block(1, 2, 3, 4, 9);
        step();
        in_valid = 1'b0;
        check("t1_I0", 64'(s_hat_I[31:0]), 64'hFF400000);
        check("t1_Q0", 64'(s_hat_Q[31:0]), 64'hFFC00000);
        check("t1_I1", 64'(s_hat_I[63:32]), 64'h00400000);
        check("t1_Q1", 64'(s_hat_Q[63:32]), 64'h00C00000);
`ifdef GRAY_MAP_EN
        check("t1_word", 64'(word_out), 64'h091E);
`else
        check("t1_word", 64'(word_out), 64'h091B);
`endif
        step();
        check("t1_sym_valid_drop", 64'(sym_valid), 64'd0);

        // T2 backpressure: one already queued, present 4 more with sink stalled
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; set_block(rk(), rk(), rk(), rk(), int'($urandom_range(0, 31)));
            step();
        end
        check("t2_count", 64'(fifo_count), 64'd4);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0; word_ready = 1'b1;
        for (int b = 0; b < 5; b++) step();
        word_ready = 1'b0;

        // T3 invalid index is sticky
        in_valid = 1'b1; set_block(0, 2, 3, 4, 3);
        step();
        check("t3_I0_zero", 64'(s_hat_I[31:0]), 64'd0);
        check("t3_err", 64'(err_idx), 64'd1);
        set_block(1, 1, 1, 1, 1);
        step();
        in_valid = 1'b0;
        check("t3_err_sticky", 64'(err_idx), 64'd1);

        // T5 simultaneous push/pop at count 2
        check("t5_pre_count", 64'(fifo_count), 64'd2);
        in_valid = 1'b1; word_ready = 1'b1; set_block(4, 3, 2, 1, 17);
        step();
        check("t5_count", 64'(fifo_count), 64'd2);
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) step();
        word_ready = 1'b0;

        // T6 async reset with three words queued
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_block(rk(), rk(), rk(), rk(), int'($urandom_range(0, 31)));
            step();
        end
        in_valid = 1'b0;
        check("t6_pre_count", 64'(fifo_count), 64'd3);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_outs", {s_hat_I, s_hat_Q}, 64'd0);
        check("t6_word_out", 64'(word_out), 64'd0);
        check("t6_flags", {sym_valid, word_valid, err_idx, s_hat_index}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_word_valid", 64'(word_valid), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            word_ready = ($urandom_range(0, 2) != 0);
            set_block(rk(), rk(), rk(), rk(), int'($urandom_range(0, 31)));
            step();
        end
        in_valid = 1'b0; word_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("final_empty", 64'(word_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
